// File: rtl/spi_ram_slave_p.sv
// spi_ram_slave_p: SPI slave with an integrated single-port RAM.
// A frame is a 3-bit opcode followed by a WIDTH-bit payload, both MSB first.
// The frame either sets the write or read address, writes RAM, or reads one
// word back on MISO. Illegal opcodes raise a one-cycle cmd_err pulse.
// Optional feature macro: SPI_ADDR_AUTOINC_EN. When it is defined, write/read
// addresses step after each completed data transfer and wrap at MEM_DEPTH.
module spi_ram_slave_p #(
  parameter int WIDTH     = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO,
  output logic cmd_err
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  localparam logic [CW-1:0]  CNT_OP_LAST = CW'(2);
  localparam logic [CW-1:0]  CNT_W_LAST  = CW'(WIDTH - 1);
  localparam logic [WIDTH:0] DEPTH_W     = (WIDTH + 1)'(MEM_DEPTH);

  localparam logic [2:0] OP_WR_ADDR = 3'b000;
  localparam logic [2:0] OP_WR_DATA = 3'b001;
  localparam logic [2:0] OP_RD_ADDR = 3'b110;
  localparam logic [2:0] OP_RD_DATA = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CMD       = 3'd1,
    ST_PAYLOAD   = 3'd2,
    ST_EXEC      = 3'd3,
    ST_READ_WAIT = 3'd4,
    ST_SEND      = 3'd5,
    ST_DISCARD   = 3'd6
  } state_t;

  // Only the four address/data opcodes are meaningful; the rest are errors.
  function automatic logic op_legal(input logic [2:0] op);
    logic ok;
    case (op)
      OP_WR_ADDR: ok = 1'b1;
      OP_WR_DATA: ok = 1'b1;
      OP_RD_ADDR: ok = 1'b1;
      OP_RD_DATA: ok = 1'b1;
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

`ifdef SPI_ADDR_AUTOINC_EN
  localparam logic [WIDTH:0] LAST_W = (WIDTH + 1)'(MEM_DEPTH - 1);

  // Address step that wraps from the last RAM word back to zero.
  function automatic logic [WIDTH-1:0] addr_next(input logic [WIDTH-1:0] a);
    logic [WIDTH-1:0] n;
    if ({1'b0, a} == LAST_W) begin
      n = {WIDTH{1'b0}};
    end else begin
      n = a + WIDTH'(1);
    end
    return n;
  endfunction
`endif

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CW-1:0]    cnt_r;
  logic [2:0]       op_r;
  logic [WIDTH-1:0] sh_r;
  logic [WIDTH-1:0] tx_r;
  logic [WIDTH-1:0] wr_addr_r;
  logic [WIDTH-1:0] rd_addr_r;
  logic             err_pend_r;
  logic             miso_r;
  logic             cmd_err_r;
  logic             miso_nxt_s;
  logic             cmd_err_nxt_s;
  logic             mem_we_s;
  logic             wr_in_range_s;
  logic             rd_in_range_s;
  logic [WIDTH-1:0] rd_data_s;

  logic [WIDTH-1:0] mem_r [0:MEM_DEPTH-1];

  assign wr_in_range_s = ({1'b0, wr_addr_r} < DEPTH_W);
  assign rd_in_range_s = ({1'b0, rd_addr_r} < DEPTH_W);
  assign mem_we_s      = (state_r == ST_EXEC) && !SS_n &&
                         (op_r == OP_WR_DATA) && wr_in_range_s;

  // Out-of-range reads return zero instead of aliasing into the RAM.
  always_comb begin
    rd_data_s = {WIDTH{1'b0}};
    if (rd_in_range_s) begin
      rd_data_s = mem_r[rd_addr_r[AW-1:0]];
    end else begin
      rd_data_s = {WIDTH{1'b0}};
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state; SS_n high always ends the frame.
  always_comb begin
    state_nxt_s = state_r;
    if (SS_n) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: state_nxt_s = ST_CMD;
        ST_CMD: begin
          if (cnt_r == CNT_OP_LAST) begin
            if (op_legal({op_r[1:0], MOSI})) begin
              state_nxt_s = ST_PAYLOAD;
            end else begin
              state_nxt_s = ST_DISCARD;
            end
          end else begin
            state_nxt_s = ST_CMD;
          end
        end
        ST_PAYLOAD: begin
          if (cnt_r == CNT_W_LAST) begin
            state_nxt_s = ST_EXEC;
          end else begin
            state_nxt_s = ST_PAYLOAD;
          end
        end
        ST_EXEC: begin
          if (op_r == OP_RD_DATA) begin
            state_nxt_s = ST_READ_WAIT;
          end else begin
            state_nxt_s = ST_DISCARD;
          end
        end
        ST_READ_WAIT: state_nxt_s = ST_SEND;
        ST_SEND: begin
          if (cnt_r == CNT_W_LAST) begin
            state_nxt_s = ST_DISCARD;
          end else begin
            state_nxt_s = ST_SEND;
          end
        end
        ST_DISCARD: state_nxt_s = ST_DISCARD;
        default:    state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Next values of the registered outputs: MISO carries the TX MSB while
  // streaming, cmd_err follows the error flag raised on the last opcode bit.
  always_comb begin
    miso_nxt_s    = 1'b0;
    cmd_err_nxt_s = err_pend_r;
    if (SS_n) begin
      miso_nxt_s = 1'b0;
    end else begin
      case (state_r)
        ST_READ_WAIT: miso_nxt_s = tx_r[WIDTH-1];
        ST_SEND: begin
          if (cnt_r == CNT_W_LAST) begin
            miso_nxt_s = 1'b0;
          end else begin
            miso_nxt_s = tx_r[WIDTH-1];
          end
        end
        default: miso_nxt_s = 1'b0;
      endcase
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miso_r    <= 1'b0;
      cmd_err_r <= 1'b0;
    end else begin
      miso_r    <= miso_nxt_s;
      cmd_err_r <= cmd_err_nxt_s;
    end
  end

  // Bit counter, opcode/payload/TX shifting and address updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r      <= {CW{1'b0}};
      op_r       <= 3'b000;
      sh_r       <= {WIDTH{1'b0}};
      tx_r       <= {WIDTH{1'b0}};
      wr_addr_r  <= {WIDTH{1'b0}};
      rd_addr_r  <= {WIDTH{1'b0}};
      err_pend_r <= 1'b0;
    end else if (SS_n) begin
      cnt_r      <= {CW{1'b0}};
      err_pend_r <= 1'b0;
    end else begin
      err_pend_r <= 1'b0;
      case (state_r)
        ST_IDLE: cnt_r <= {CW{1'b0}};
        ST_CMD: begin
          op_r <= {op_r[1:0], MOSI};
          if (cnt_r == CNT_OP_LAST) begin
            cnt_r      <= {CW{1'b0}};
            err_pend_r <= !op_legal({op_r[1:0], MOSI});
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        ST_PAYLOAD: begin
          sh_r <= {sh_r[WIDTH-2:0], MOSI};
          if (cnt_r == CNT_W_LAST) begin
            cnt_r <= {CW{1'b0}};
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        ST_EXEC: begin
          cnt_r <= {CW{1'b0}};
          case (op_r)
            OP_WR_ADDR: wr_addr_r <= sh_r;
            OP_WR_DATA: begin
`ifdef SPI_ADDR_AUTOINC_EN
              wr_addr_r <= addr_next(wr_addr_r);
`endif
            end
            OP_RD_ADDR: rd_addr_r <= sh_r;
            OP_RD_DATA: tx_r <= rd_data_s;
            default: ;
          endcase
        end
        ST_READ_WAIT: begin
          cnt_r <= {CW{1'b0}};
          tx_r  <= {tx_r[WIDTH-2:0], 1'b0};
        end
        ST_SEND: begin
          if (cnt_r == CNT_W_LAST) begin
            cnt_r <= {CW{1'b0}};
`ifdef SPI_ADDR_AUTOINC_EN
            rd_addr_r <= addr_next(rd_addr_r);
`endif
          end else begin
            cnt_r <= cnt_r + CW'(1);
            tx_r  <= {tx_r[WIDTH-2:0], 1'b0};
          end
        end
        ST_DISCARD: cnt_r <= {CW{1'b0}};
        default:    cnt_r <= {CW{1'b0}};
      endcase
    end
  end

  // RAM write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[wr_addr_r[AW-1:0]] <= sh_r;
    end
  end

  assign MISO    = miso_r;
  assign cmd_err = cmd_err_r;

endmodule

// File: tb/tb_spi_ram_slave_p.sv
// Directed testbench for spi_ram_slave_p. Two instances share the SPI inputs:
// u_dut_a has a full 256-word RAM, u_dut_b only 128 words, so addresses at or
// above 0x80 exercise the out-of-range behaviour on the second one.
module tb_spi_ram_slave_p;

  logic clk = 1'b0;
  logic rst_n;
  logic SS_n;
  logic MOSI;
  logic miso_a, err_a, miso_b, err_b;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  spi_ram_slave_p #(.WIDTH(8), .MEM_DEPTH(256)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI),
    .MISO(miso_a), .cmd_err(err_a)
  );

  spi_ram_slave_p #(.WIDTH(8), .MEM_DEPTH(128)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI),
    .MISO(miso_b), .cmd_err(err_b)
  );

  typedef struct {
    logic [2:0] op;
    logic [7:0] pay;
    int         ncyc;
    logic [7:0] exp_a;
    logic [7:0] exp_b;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic is_illegal(input logic [2:0] op);
    return (op == 3'b010) || (op == 3'b011) || (op == 3'b100) || (op == 3'b101);
  endfunction

  // Expected MISO trace: data bit k (MSB first) seen after edge P13+k.
  function automatic logic [31:0] exp_miso(input logic [7:0] d, input int ncyc);
    logic [31:0] t;
    t = 32'h0;
    for (int k = 0; k < 8; k++) begin
      if (13 + k < ncyc) t[13 + k] = d[7 - k];
    end
    return t;
  endfunction

  // One frame of ncyc posedges (P0..P(ncyc-1)); trace[p] is the output value
  // just after edge Pp. If rst_at >= 0, reset is asserted right after P(rst_at).
  task automatic run_frame(input logic [2:0] op, input logic [7:0] pay,
                           input int ncyc, input int rst_at,
                           output logic [31:0] tma, output logic [31:0] tea,
                           output logic [31:0] tmb, output logic [31:0] teb);
    logic [10:0] bits;
    bits = {op, pay};
    tma = 32'h0; tea = 32'h0; tmb = 32'h0; teb = 32'h0;
    @(negedge clk);
    SS_n = 1'b0;
    MOSI = 1'b0;
    for (int p = 0; p < ncyc; p++) begin
      @(posedge clk);
      @(negedge clk);
      tma[p] = miso_a; tea[p] = err_a;
      tmb[p] = miso_b; teb[p] = err_b;
      if (p + 1 >= 1 && p + 1 <= 11) MOSI = bits[10 - p];
      else MOSI = 1'b0;
      if (p == rst_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_mid_miso", {31'h0, miso_a}, 32'h0);
        check("rst_mid_err", {31'h0, err_a}, 32'h0);
        break;
      end
    end
    SS_n = 1'b1;
    MOSI = 1'b0;
    if (rst_at >= 0) begin
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
    end
  endtask

  task automatic apply(input string name, input vec_t v);
    logic [31:0] tma, tea, tmb, teb, em_a, em_b, ee;
    run_frame(v.op, v.pay, v.ncyc, -1, tma, tea, tmb, teb);
    em_a = (v.op == 3'b111) ? exp_miso(v.exp_a, v.ncyc) : 32'h0;
    em_b = (v.op == 3'b111) ? exp_miso(v.exp_b, v.ncyc) : 32'h0;
    ee   = is_illegal(v.op) ? 32'h0000_0010 : 32'h0;
    check({name, "_miso_a"}, tma, em_a);
    check({name, "_err_a"}, tea, ee);
    check({name, "_miso_b"}, tmb, em_b);
    check({name, "_err_b"}, teb, ee);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] tma, tea, tmb, teb;
    vec_t v;

    rst_n = 1'b0;
    SS_n  = 1'b1;
    MOSI  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_miso", {31'h0, miso_a}, 32'h0);
    check("reset_err", {31'h0, err_a}, 32'h0);
    rst_n = 1'b1;

    // op, payload, cycles, expected read byte on dut_a / dut_b
    tbl.push_back('{3'b000, 8'h00, 14, 8'h00, 8'h00});
    tbl.push_back('{3'b001, 8'h5A, 14, 8'h00, 8'h00});
    tbl.push_back('{3'b000, 8'h12, 14, 8'h00, 8'h00});
    tbl.push_back('{3'b001, 8'hA5, 14, 8'h00, 8'h00});
    tbl.push_back('{3'b110, 8'h12, 14, 8'h00, 8'h00});
    tbl.push_back('{3'b111, 8'h00, 22, 8'hA5, 8'hA5});
    tbl.push_back('{3'b010, 8'h34, 14, 8'h00, 8'h00});
    tbl.push_back('{3'b111, 8'hFF, 22, 8'hA5, 8'hA5});
    tbl.push_back('{3'b000, 8'h40, 14, 8'h00, 8'h00});
    tbl.push_back('{3'b011, 8'h77, 14, 8'h00, 8'h00});
    tbl.push_back('{3'b001, 8'h3C, 14, 8'h00, 8'h00});
    tbl.push_back('{3'b100, 8'h12, 14, 8'h00, 8'h00});
    tbl.push_back('{3'b110, 8'h40, 14, 8'h00, 8'h00});
    tbl.push_back('{3'b101, 8'h00, 14, 8'h00, 8'h00});
    tbl.push_back('{3'b111, 8'h00, 22, 8'h3C, 8'h3C});
    tbl.push_back('{3'b000, 8'h90, 14, 8'h00, 8'h00});
    tbl.push_back('{3'b001, 8'h77, 14, 8'h00, 8'h00});
    tbl.push_back('{3'b110, 8'h90, 14, 8'h00, 8'h00});
    tbl.push_back('{3'b111, 8'h00, 22, 8'h77, 8'h00});
    tbl.push_back('{3'b000, 8'hFF, 14, 8'h00, 8'h00});
    tbl.push_back('{3'b001, 8'hC3, 14, 8'h00, 8'h00});
    tbl.push_back('{3'b110, 8'hFF, 14, 8'h00, 8'h00});
    tbl.push_back('{3'b111, 8'h00, 22, 8'hC3, 8'h00});
    tbl.push_back('{3'b110, 8'h00, 14, 8'h00, 8'h00});
    tbl.push_back('{3'b111, 8'h00, 22, 8'h5A, 8'h5A});

    for (int i = 0; i < tbl.size(); i++) begin
      apply($sformatf("vec%0d", i), tbl[i]);
    end

    // Write-data frame cut after 5 payload bits: RAM[0x12] keeps 0xA5.
    apply("abw_addr", '{3'b000, 8'h12, 14, 8'h00, 8'h00});
    run_frame(3'b001, 8'hFF, 9, -1, tma, tea, tmb, teb);
    check("abw_err", tea, 32'h0);
    apply("abw_rda", '{3'b110, 8'h12, 14, 8'h00, 8'h00});
    apply("abw_read", '{3'b111, 8'h00, 22, 8'hA5, 8'hA5});

    // Read-data frame cut during SEND: partial bits, MISO low on the SS_n edge.
    apply("abr_rda", '{3'b110, 8'h12, 14, 8'h00, 8'h00});
    run_frame(3'b111, 8'h00, 17, -1, tma, tea, tmb, teb);
    check("abr_partial", tma, exp_miso(8'hA5, 17));
    @(posedge clk);
    #1;
    check("abr_miso_low", {31'h0, miso_a}, 32'h0);
    apply("abr_reread", '{3'b111, 8'h00, 22, 8'hA5, 8'hA5});

    // Reset during SEND: MISO drops at once, rd_addr returns to 0.
    apply("rst_rda", '{3'b110, 8'h12, 14, 8'h00, 8'h00});
    run_frame(3'b111, 8'h00, 22, 15, tma, tea, tmb, teb);
    check("rst_partial", tma & 32'h0000_E000, exp_miso(8'hA5, 16));
    apply("rst_read0", '{3'b111, 8'h00, 22, 8'h5A, 8'h5A});
    apply("rst_wr0", '{3'b001, 8'h66, 14, 8'h00, 8'h00});
    apply("rst_rda0", '{3'b110, 8'h00, 14, 8'h00, 8'h00});
    apply("rst_rd0", '{3'b111, 8'h00, 22, 8'h66, 8'h66});

`ifdef SPI_ADDR_AUTOINC_EN
    // Burst with wrap at the end of the 256-word RAM (dut_a only).
    apply("ai_wa", '{3'b000, 8'hFF, 14, 8'h00, 8'h00});
    run_frame(3'b001, 8'h11, 14, -1, tma, tea, tmb, teb);
    run_frame(3'b001, 8'h22, 14, -1, tma, tea, tmb, teb);
    apply("ai_ra", '{3'b110, 8'hFF, 14, 8'h00, 8'h00});
    run_frame(3'b111, 8'h00, 22, -1, tma, tea, tmb, teb);
    check("ai_rd_ff", tma, exp_miso(8'h11, 22));
    run_frame(3'b111, 8'h00, 22, -1, tma, tea, tmb, teb);
    check("ai_rd_00", tma, exp_miso(8'h22, 22));
`else
    // Without auto-increment, repeated reads hit the same word.
    apply("na_ra", '{3'b110, 8'h40, 14, 8'h00, 8'h00});
    apply("na_rd1", '{3'b111, 8'h00, 22, 8'h3C, 8'h3C});
    apply("na_rd2", '{3'b111, 8'h00, 22, 8'h3C, 8'h3C});
    apply("na_wr", '{3'b001, 8'h99, 14, 8'h00, 8'h00});
    apply("na_ra0", '{3'b110, 8'h00, 14, 8'h00, 8'h00});
    apply("na_rd0", '{3'b111, 8'h00, 22, 8'h99, 8'h99});
`endif

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
